// File: rtl/lsu_pkg.sv
// Shared encodings for the load/store unit: access sizes, FSM states,
// byte-lane offsets and the latched request record.
package lsu_pkg;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_RD        = 3'd1;
  localparam logic [2:0] ST_RD_DATA   = 3'd2;
  localparam logic [2:0] ST_RMW_RD    = 3'd3;
  localparam logic [2:0] ST_RMW_MERGE = 3'd4;
  localparam logic [2:0] ST_WR        = 3'd5;

  // Little-endian lane positions inside a 32-bit word.
  localparam int LANE0_LSB = 0;
  localparam int LANE1_LSB = 8;
  localparam int LANE2_LSB = 16;
  localparam int LANE3_LSB = 24;

  typedef struct packed {
    logic        write;
    logic [1:0]  size;
    logic        is_unsigned;
    logic [1:0]  offset;
    logic [15:0] wdata;
  } lsu_req_t;

  // Reserved size 2'b11 behaves as a word access.
  function automatic logic size_is_word(input logic [1:0] size);
    return size[1];
  endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Combinational lane logic: extracts and extends load data, and merges
// sub-word store data into a word read back from memory.
module lsu_lane_align
  import lsu_pkg::*;
(
  input  logic [31:0] mem_word,
  input  logic [15:0] new_data,
  input  logic [1:0]  size,
  input  logic [1:0]  offset,
  input  logic        is_unsigned,
  output logic [31:0] load_data,
  output logic [31:0] merged_word
);

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  always_comb begin
    byte_lane = mem_word[LANE0_LSB +: 8];
    case (offset)
      2'd1:    byte_lane = mem_word[LANE1_LSB +: 8];
      2'd2:    byte_lane = mem_word[LANE2_LSB +: 8];
      2'd3:    byte_lane = mem_word[LANE3_LSB +: 8];
      default: byte_lane = mem_word[LANE0_LSB +: 8];
    endcase
    // Halves only look at offset[1], so an unchecked odd address folds down.
    half_lane = offset[1] ? mem_word[LANE2_LSB +: 16] : mem_word[LANE0_LSB +: 16];

    case (size)
      SIZE_BYTE: load_data = is_unsigned ? {24'h0, byte_lane} : {{24{byte_lane[7]}}, byte_lane};
      SIZE_HALF: load_data = is_unsigned ? {16'h0, half_lane} : {{16{half_lane[15]}}, half_lane};
      default:   load_data = mem_word;
    endcase
  end

  always_comb begin
    merged_word = mem_word;
    case (size)
      SIZE_BYTE: begin
        case (offset)
          2'd1:    merged_word[LANE1_LSB +: 8] = new_data[7:0];
          2'd2:    merged_word[LANE2_LSB +: 8] = new_data[7:0];
          2'd3:    merged_word[LANE3_LSB +: 8] = new_data[7:0];
          default: merged_word[LANE0_LSB +: 8] = new_data[7:0];
        endcase
      end
      SIZE_HALF: begin
        if (offset[1]) merged_word[LANE2_LSB +: 16] = new_data;
        else           merged_word[LANE0_LSB +: 16] = new_data;
      end
      default: merged_word = mem_word;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Memory-stage load/store unit: word-wide memory accesses with lane extract,
// sign/zero extension and read-modify-write for sub-word stores.
// Optional build macro LSU_MISALIGN_CHECK_EN rejects misaligned half/word accesses.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int CORE         = 0,
  parameter int DATA_WIDTH   = 32,
  parameter int ADDRESS_BITS = 20
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    req_valid,
  input  logic                    req_write,
  input  logic [1:0]              req_size,
  input  logic                    req_unsigned,
  input  logic [ADDRESS_BITS-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0]   req_wdata,
  output logic                    req_ready,
  output logic                    resp_valid,
  output logic [DATA_WIDTH-1:0]   resp_rdata,
  output logic                    resp_misaligned,
  output logic                    mem_read,
  output logic                    mem_write,
  output logic [ADDRESS_BITS-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0]   mem_wdata,
  input  logic [DATA_WIDTH-1:0]   mem_rdata
);

  if (CORE < 0 || DATA_WIDTH != 32) begin : g_cfg_check
    $error("load_store_unit: lane logic requires DATA_WIDTH == 32 and CORE >= 0");
  end

  logic [2:0]  state_reg;
  lsu_req_t    req_reg;
  logic        misaligned;
  logic [31:0] load_data;
  logic [31:0] merged_word;

`ifdef LSU_MISALIGN_CHECK_EN
  always_comb begin
    case (req_size)
      SIZE_BYTE: misaligned = 1'b0;
      SIZE_HALF: misaligned = req_addr[0];
      default:   misaligned = |req_addr[1:0];
    endcase
  end
`else
  assign misaligned = 1'b0;
`endif

  lsu_lane_align u_lane_align (
    .mem_word    (mem_rdata),
    .new_data    (req_reg.wdata),
    .size        (req_reg.size),
    .offset      (req_reg.offset),
    .is_unsigned (req_reg.is_unsigned),
    .load_data   (load_data),
    .merged_word (merged_word)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_reg       <= ST_IDLE;
      req_reg         <= '0;
      req_ready       <= 1'b1;
      resp_valid      <= 1'b0;
      resp_rdata      <= '0;
      resp_misaligned <= 1'b0;
      mem_read        <= 1'b0;
      mem_write       <= 1'b0;
      mem_addr        <= '0;
      mem_wdata       <= '0;
    end else begin
      resp_valid <= 1'b0;
      mem_read   <= 1'b0;
      mem_write  <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (req_valid && req_ready) begin
            if (misaligned) begin
              // Rejected without touching memory; stay ready.
              resp_valid      <= 1'b1;
              resp_rdata      <= '0;
              resp_misaligned <= 1'b1;
            end else begin
              req_reg   <= '{write: req_write, size: req_size, is_unsigned: req_unsigned,
                             offset: req_addr[1:0], wdata: req_wdata[15:0]};
              mem_addr  <= {2'b00, req_addr[ADDRESS_BITS-1:2]};
              req_ready <= 1'b0;
              if (!req_write) begin
                state_reg <= ST_RD;
                mem_read  <= 1'b1;
              end else if (size_is_word(req_size)) begin
                state_reg <= ST_WR;
                mem_write <= 1'b1;
                mem_wdata <= req_wdata;
              end else begin
                state_reg <= ST_RMW_RD;
                mem_read  <= 1'b1;
              end
            end
          end
        end
        ST_RD:    state_reg <= ST_RD_DATA;
        ST_RD_DATA: begin
          state_reg       <= ST_IDLE;
          req_ready       <= 1'b1;
          resp_valid      <= 1'b1;
          resp_rdata      <= load_data;
          resp_misaligned <= 1'b0;
        end
        ST_RMW_RD: state_reg <= ST_RMW_MERGE;
        ST_RMW_MERGE: begin
          state_reg <= ST_WR;
          mem_write <= 1'b1;
          mem_wdata <= merged_word;
        end
        ST_WR: begin
          state_reg       <= ST_IDLE;
          req_ready       <= 1'b1;
          resp_valid      <= 1'b1;
          resp_rdata      <= '0;
          resp_misaligned <= 1'b0;
        end
        default: begin
          state_reg <= ST_IDLE;
          req_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a one-cycle-latency word memory model.
module tb_load_store_unit;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_write = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic        req_unsigned = 1'b0;
  logic [19:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        req_ready, resp_valid, resp_misaligned, mem_read, mem_write;
  logic [31:0] resp_rdata, mem_wdata;
  logic [31:0] mem_rdata = '0;
  logic [19:0] mem_addr;

  logic [31:0] mem [256];
  int checks = 0;
  int errors = 0;

  int lat, rd_cnt, wr_cnt, first_rd, first_wr;
  logic [31:0] rd_addr, wr_addr, wr_data, got_rdata;
  logic got_mis;

  load_store_unit #(.CORE(0), .DATA_WIDTH(32), .ADDRESS_BITS(20)) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_write(req_write), .req_size(req_size),
    .req_unsigned(req_unsigned), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_ready(req_ready), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .resp_misaligned(resp_misaligned), .mem_read(mem_read), .mem_write(mem_write),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clock = ~clock;

  always @(posedge clock) begin
    if (mem_read)  mem_rdata <= mem[mem_addr[7:0]];
    if (mem_write) mem[mem_addr[7:0]] <= mem_wdata;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Issue one request, then watch memory traffic until the response (bounded).
  task automatic run_req(input logic wr, input logic [1:0] sz, input logic uns,
                         input logic [19:0] addr, input logic [31:0] wd);
    req_write = wr; req_size = sz; req_unsigned = uns; req_addr = addr; req_wdata = wd;
    req_valid = 1'b1;
    step();
    req_valid = 1'b0;
    lat = -1; rd_cnt = 0; wr_cnt = 0; first_rd = -1; first_wr = -1;
    for (int k = 1; k <= 12; k++) begin
      if (mem_read && mem_write) chk("rw_exclusive", 32'd1, 32'd0);
      if (mem_read) begin
        rd_cnt++;
        if (first_rd < 0) begin first_rd = k; rd_addr = 32'(mem_addr); end
      end
      if (mem_write) begin
        wr_cnt++;
        if (first_wr < 0) begin first_wr = k; wr_addr = 32'(mem_addr); wr_data = mem_wdata; end
      end
      if (resp_valid) begin
        lat = k; got_rdata = resp_rdata; got_mis = resp_misaligned;
        break;
      end
      step();
    end
    chk("ready_with_resp", 32'(req_ready), 32'd1);
  endtask

  task automatic do_load(input string tag, input logic [1:0] sz, input logic uns,
                         input logic [19:0] addr, input logic [31:0] exp);
    run_req(1'b0, sz, uns, addr, 32'h0);
    $display("load  %s addr=%h size=%0d uns=%0d -> rdata=%h lat=%0d", tag, addr, sz, uns, got_rdata, lat);
    chk({tag, "_lat"}, 32'(lat), 32'd3);
    chk({tag, "_rd_cycle"}, 32'(first_rd), 32'd1);
    chk({tag, "_rd_addr"}, rd_addr, 32'(addr >> 2));
    chk({tag, "_traffic"}, 32'(rd_cnt * 16 + wr_cnt), 32'd16);
    chk({tag, "_rdata"}, got_rdata, exp);
    chk({tag, "_mis"}, 32'(got_mis), 32'd0);
  endtask

  task automatic do_sub_store(input string tag, input logic [1:0] sz, input logic [19:0] addr,
                              input logic [31:0] wd, input logic [31:0] exp_word);
    run_req(1'b1, sz, 1'b0, addr, wd);
    $display("store %s addr=%h size=%0d -> wdata=%h lat=%0d", tag, addr, sz, wr_data, lat);
    chk({tag, "_lat"}, 32'(lat), 32'd4);
    chk({tag, "_rd_cycle"}, 32'(first_rd), 32'd1);
    chk({tag, "_wr_cycle"}, 32'(first_wr), 32'd3);
    chk({tag, "_traffic"}, 32'(rd_cnt * 16 + wr_cnt), 32'd17);
    chk({tag, "_wr_addr"}, wr_addr, 32'(addr >> 2));
    chk({tag, "_wdata"}, wr_data, exp_word);
    chk({tag, "_rdata"}, got_rdata, 32'h0);
  endtask

  int pulses;

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    mem[8'h40] = 32'h8899AABB;

    // Reset state
    repeat (3) @(posedge clock);
    #1;
    $display("reset req_ready=%0d resp_valid=%0d mem_read=%0d mem_write=%0d", req_ready, resp_valid, mem_read, mem_write);
    chk("rst_ready", 32'(req_ready), 32'd1);
    chk("rst_outputs", {26'h0, resp_valid, resp_misaligned, mem_read, mem_write, |mem_addr, |mem_wdata}, 32'h0);
    chk("rst_rdata", resp_rdata, 32'h0);
    reset = 1'b1;
    step();

    do_load("lb_s", 2'b00, 1'b0, 20'h101, 32'hFFFFFFAA);
    do_load("lb_u", 2'b00, 1'b1, 20'h101, 32'h000000AA);
    do_load("lh_s", 2'b01, 1'b0, 20'h102, 32'hFFFF8899);
    do_load("lw",   2'b10, 1'b0, 20'h100, 32'h8899AABB);
    step();
    $display("hold  resp_valid=%0d resp_rdata=%h", resp_valid, resp_rdata);
    chk("hold_valid", 32'(resp_valid), 32'd0);
    chk("hold_rdata", resp_rdata, 32'h8899AABB);

    do_sub_store("sb", 2'b00, 20'h103, 32'hAAAAAA5C, 32'h5C99AABB);
    do_sub_store("sh", 2'b01, 20'h100, 32'hFFFF1234, 32'h5C991234);
    do_load("lh_u", 2'b01, 1'b1, 20'h102, 32'h00005C99);
    do_load("lb_s3", 2'b00, 1'b0, 20'h103, 32'h0000005C);

    // Word store: no read, write in the first cycle after accept
    run_req(1'b1, 2'b10, 1'b0, 20'h104, 32'hDEADBEEF);
    $display("store sw addr=00104 -> wdata=%h lat=%0d reads=%0d", wr_data, lat, rd_cnt);
    chk("sw_lat", 32'(lat), 32'd2);
    chk("sw_wr_cycle", 32'(first_wr), 32'd1);
    chk("sw_wr_addr", wr_addr, 32'h41);
    chk("sw_wdata", wr_data, 32'hDEADBEEF);
    chk("sw_reads", 32'(rd_cnt), 32'd0);

    // Request held through a busy period is taken only once ready returns
    req_write = 1'b1; req_size = 2'b10; req_addr = 20'h108; req_wdata = 32'h01234567;
    req_valid = 1'b1;
    step();
    req_write = 1'b0; req_addr = 20'h108; req_wdata = 32'h0;
    $display("busy  req_ready=%0d mem_write=%0d", req_ready, mem_write);
    chk("busy_ready", 32'(req_ready), 32'd0);
    chk("busy_write", 32'(mem_write), 32'd1);
    step();
    chk("busy_resp", {30'h0, resp_valid, req_ready}, 32'd3);
    step();
    req_valid = 1'b0;
    $display("busy  held load: mem_read=%0d mem_addr=%h", mem_read, mem_addr);
    chk("held_read", {31'h0, mem_read}, 32'd1);
    chk("held_addr", 32'(mem_addr), 32'h42);
    step();
    step();
    $display("busy  held load resp_valid=%0d rdata=%h", resp_valid, resp_rdata);
    chk("held_resp", 32'(resp_valid), 32'd1);
    chk("held_rdata", resp_rdata, 32'h01234567);

    // Misaligned half load at 0x101
    run_req(1'b0, 2'b01, 1'b0, 20'h101, 32'h0);
    $display("mis   lh 00101 -> lat=%0d mis=%0d rdata=%h traffic=%0d", lat, got_mis, got_rdata, rd_cnt + wr_cnt);
`ifdef LSU_MISALIGN_CHECK_EN
    chk("mis_lat", 32'(lat), 32'd1);
    chk("mis_flag", 32'(got_mis), 32'd1);
    chk("mis_traffic", 32'(rd_cnt + wr_cnt), 32'd0);
    chk("mis_rdata", got_rdata, 32'h0);
`else
    chk("mis_lat", 32'(lat), 32'd3);
    chk("mis_flag", 32'(got_mis), 32'd0);
    chk("mis_rdata", got_rdata, 32'h00001234);
    do_load("lw_mis", 2'b10, 1'b0, 20'h102, 32'h5C991234);
`endif

    // Reset during the write phase of a sub-word store
    req_write = 1'b1; req_size = 2'b00; req_addr = 20'h105; req_wdata = 32'h77;
    req_valid = 1'b1;
    step();
    req_valid = 1'b0;
    step();
    step();
    chk("rmw_wr_before_rst", 32'(mem_write), 32'd1);
    reset = 1'b0;
    #1;
    $display("reset mid-WR: mem_write=%0d req_ready=%0d", mem_write, req_ready);
    chk("rst_mid_write", 32'(mem_write), 32'd0);
    chk("rst_mid_ready", 32'(req_ready), 32'd1);
    step();
    reset = 1'b1;
    pulses = 0;
    for (int k = 0; k < 4; k++) begin
      if (resp_valid) pulses++;
      step();
    end
    chk("rst_no_resp", 32'(pulses), 32'd0);
    do_load("post_rst", 2'b10, 1'b0, 20'h104, 32'hDEADBEEF);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
